// File: rtl/frame_strobe_ctrl.sv
// Config-word sequencer: finds the sync word, parses frame headers and drives
// FrameData plus a one-hot FrameStrobe so each frame latch captures exactly once.
module frame_strobe_ctrl #(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter logic [FrameBitsPerRow-1:0] SyncWord = 32'hFAB0_FAB1,
  parameter int StrobeCycles = 2
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [FrameBitsPerRow-1:0] WordData,
  input  logic                       WordValid,
  output logic                       WordReady,
  output logic [FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic                       Busy,
  output logic                       ConfigDone,
  output logic                       Error
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HEADER = 3'd1,
    DATA   = 3'd2,
    STROBE = 3'd3,
    HOLD   = 3'd4,
    SKIP   = 3'd5
  } state_t;

  state_t                       state_r, state_s;
  logic [FrameBitsPerRow-1:0]   data_r, data_s;
  logic [MaxFramesPerCol-1:0]   strobe_r, strobe_s, onehot_s;
  logic [3:0]                   cnt_r, cnt_s;
  logic [7:0]                   idx_r, idx_s;
  logic                         done_r, done_s;
  logic                         err_r, err_s;
  logic                         ready_r, ready_s;
  logic                         busy_r, busy_s;
  logic                         accept_s;

  // Decode the latched frame index into a one-hot latch enable
  always_comb begin
    onehot_s = '0;
    for (int i = 0; i < MaxFramesPerCol; i++) begin
      if (idx_r == 8'(i)) begin
        onehot_s[i] = 1'b1;
      end else begin
        onehot_s[i] = 1'b0;
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_s  = state_r;
    data_s   = data_r;
    strobe_s = strobe_r;
    cnt_s    = cnt_r;
    idx_s    = idx_r;
    done_s   = 1'b0;
    err_s    = err_r;
    accept_s = WordValid && ready_r;

    case (state_r)
      IDLE: begin
        if (accept_s && (WordData == SyncWord)) begin
          state_s = HEADER;
          err_s   = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      HEADER: begin
        if (!accept_s) begin
          state_s = HEADER;
        end else if (WordData[31]) begin
          state_s = IDLE;
          done_s  = 1'b1;
        end else if (32'(WordData[7:0]) < 32'(MaxFramesPerCol)) begin
          state_s = DATA;
          idx_s   = WordData[7:0];
        end else begin
          state_s = SKIP;
          err_s   = 1'b1;
        end
      end
      DATA: begin
        if (accept_s) begin
          state_s  = STROBE;
          data_s   = WordData;
          strobe_s = onehot_s;
          cnt_s    = 4'(StrobeCycles);
        end else begin
          state_s = DATA;
        end
      end
      // Counter was loaded with the full width, so the last strobe cycle sees 1
      STROBE: begin
        if (cnt_r == 4'd1) begin
          state_s  = HOLD;
          strobe_s = '0;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      HOLD: begin
        state_s = HEADER;
      end
      SKIP: begin
        if (accept_s) begin
          state_s = HEADER;
        end else begin
          state_s = SKIP;
        end
      end
      default: begin
        state_s  = IDLE;
        strobe_s = '0;
      end
    endcase

    ready_s = !((state_s == STROBE) || (state_s == HOLD));
    busy_s  = (state_s != IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r  <= IDLE;
      data_r   <= '0;
      strobe_r <= '0;
      cnt_r    <= 4'd0;
      idx_r    <= 8'd0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
      ready_r  <= 1'b1;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      data_r   <= data_s;
      strobe_r <= strobe_s;
      cnt_r    <= cnt_s;
      idx_r    <= idx_s;
      done_r   <= done_s;
      err_r    <= err_s;
      ready_r  <= ready_s;
      busy_r   <= busy_s;
    end
  end

  assign WordReady   = ready_r;
  assign FrameData   = data_r;
  assign FrameStrobe = strobe_r;
  assign Busy        = busy_r;
  assign ConfigDone  = done_r;
  assign Error       = err_r;

endmodule

// File: tb/tb_frame_strobe_ctrl.sv
// Directed bench for frame_strobe_ctrl: one instance with 2-cycle strobes and a
// second with 1-cycle strobes fed the same word stream.
module tb_frame_strobe_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] WordData = 32'd0;
  logic        WordValid = 1'b0;

  logic        rdy2, rdy1;
  logic [31:0] fd2, fd1;
  logic [19:0] fs2, fs1;
  logic        busy2, busy1, done2, done1, err2, err1;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  frame_strobe_ctrl #(.StrobeCycles(2)) dut2 (
    .CLK(CLK), .RST(RST), .WordData(WordData), .WordValid(WordValid),
    .WordReady(rdy2), .FrameData(fd2), .FrameStrobe(fs2), .Busy(busy2),
    .ConfigDone(done2), .Error(err2)
  );

  frame_strobe_ctrl #(.StrobeCycles(1)) dut1 (
    .CLK(CLK), .RST(RST), .WordData(WordData), .WordValid(WordValid),
    .WordReady(rdy1), .FrameData(fd1), .FrameStrobe(fs1), .Busy(busy1),
    .ConfigDone(done1), .Error(err1)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic put(input logic [31:0] w);
    WordData  = w;
    WordValid = 1'b1;
    tick();
  endtask

  initial begin
    // Reset
    tick(); tick();
    RST = 1'b0;
    check_eq("rst_data",   fd2, 32'd0);
    check_eq("rst_strobe", 32'(fs2), 32'd0);
    check_eq("rst_done",   32'(done2), 32'd0);
    check_eq("rst_err",    32'(err2), 32'd0);
    check_eq("rst_ready",  32'(rdy2), 32'd1);
    check_eq("rst_busy",   32'(busy2), 32'd0);

    // Basic frame: index 3, then end of config
    put(32'hFAB0_FAB1);
    check_eq("sync_busy", 32'(busy2), 32'd1);
    put(32'h0000_0003);
    put(32'hDEAD_BEEF);
    WordValid = 1'b0;
    check_eq("f3_strobe_c1", 32'(fs2), 32'h0000_0008);
    check_eq("f3_data_c1",   fd2, 32'hDEAD_BEEF);
    check_eq("f3_ready_c1",  32'(rdy2), 32'd0);
    tick();
    check_eq("f3_strobe_c2", 32'(fs2), 32'h0000_0008);
    check_eq("f3_data_c2",   fd2, 32'hDEAD_BEEF);
    tick();
    check_eq("f3_strobe_hold", 32'(fs2), 32'd0);
    check_eq("f3_ready_hold",  32'(rdy2), 32'd0);
    check_eq("f3_data_hold",   fd2, 32'hDEAD_BEEF);
    tick();
    check_eq("f3_ready_back", 32'(rdy2), 32'd1);
    put(32'h8000_0000);
    WordValid = 1'b0;
    check_eq("eoc_done", 32'(done2), 32'd1);
    check_eq("eoc_busy", 32'(busy2), 32'd0);
    tick();
    check_eq("eoc_done_pulse", 32'(done2), 32'd0);

    // Words before sync are ignored
    put(32'h1234_5678);
    check_eq("presync_busy", 32'(busy2), 32'd0);
    put(32'hFAB0_FAB1);
    check_eq("postsync_busy", 32'(busy2), 32'd1);

    // Out-of-range index sets Error and skips its data word
    put(32'h0000_0019);
    check_eq("oor_err", 32'(err2), 32'd1);
    put(32'hFFFF_FFFF);
    check_eq("skip_strobe", 32'(fs2), 32'd0);
    check_eq("skip_data",   fd2, 32'hDEAD_BEEF);
    check_eq("skip_ready",  32'(rdy2), 32'd1);
    put(32'h0000_0005);
    put(32'h0000_A5A5);
    WordValid = 1'b0;
    check_eq("f5_strobe", 32'(fs2), 32'h0000_0020);
    check_eq("f5_data",   fd2, 32'h0000_A5A5);
    tick(); tick(); tick();
    put(32'h8000_0000);
    check_eq("done_keeps_err", 32'(err2), 32'd1);
    put(32'hFAB0_FAB1);
    check_eq("sync_clears_err", 32'(err2), 32'd0);

    // Back-to-back frames 0 and 19 with WordValid held high
    put(32'h0000_0000);
    put(32'h1111_1111);
    WordData = 32'h0000_0013;
    check_eq("f0_strobe_c1", 32'(fs2), 32'h0000_0001);
    check_eq("f0_ready_c1",  32'(rdy2), 32'd0);
    tick();
    check_eq("f0_strobe_c2", 32'(fs2), 32'h0000_0001);
    check_eq("f0_data_c2",   fd2, 32'h1111_1111);
    check_eq("f0_ready_c2",  32'(rdy2), 32'd0);
    tick();
    check_eq("f0_strobe_hold", 32'(fs2), 32'd0);
    check_eq("f0_ready_hold",  32'(rdy2), 32'd0);
    check_eq("f0_data_hold",   fd2, 32'h1111_1111);
    tick();
    check_eq("f0_ready_back", 32'(rdy2), 32'd1);
    tick();
    put(32'h2222_2222);
    check_eq("f19_strobe_c1", 32'(fs2), 32'h0008_0000);
    check_eq("f19_data_c1",   fd2, 32'h2222_2222);
    tick();
    check_eq("f19_strobe_c2", 32'(fs2), 32'h0008_0000);
    tick();
    check_eq("f19_strobe_hold", 32'(fs2), 32'd0);
    tick();

    // Reset on the first strobe cycle
    put(32'h0000_0002);
    put(32'h3333_3333);
    WordValid = 1'b0;
    check_eq("f2_strobe_c1", 32'(fs2), 32'h0000_0004);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check_eq("midrst_strobe", 32'(fs2), 32'd0);
    check_eq("midrst_data",   fd2, 32'd0);
    check_eq("midrst_busy",   32'(busy2), 32'd0);
    check_eq("midrst_ready",  32'(rdy2), 32'd1);
    put(32'hFAB0_FAB1);
    check_eq("midrst_resync", 32'(busy2), 32'd1);

    // Valid gaps between header and data; both strobe widths
    put(32'h0000_0001);
    WordValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("gap_strobe2", 32'(fs2), 32'd0);
      check_eq("gap_strobe1", 32'(fs1), 32'd0);
    end
    put(32'h4444_4444);
    WordValid = 1'b0;
    check_eq("gap_s2_c1", 32'(fs2), 32'h0000_0002);
    check_eq("gap_s1_c1", 32'(fs1), 32'h0000_0002);
    check_eq("gap_s1_data", fd1, 32'h4444_4444);
    tick();
    check_eq("gap_s2_c2", 32'(fs2), 32'h0000_0002);
    check_eq("gap_s1_hold", 32'(fs1), 32'd0);
    check_eq("gap_s1_ready_hold", 32'(rdy1), 32'd0);
    tick();
    check_eq("gap_s2_hold", 32'(fs2), 32'd0);
    check_eq("gap_s1_ready_back", 32'(rdy1), 32'd1);
    check_eq("gap_s2_ready_hold", 32'(rdy2), 32'd0);
    tick();
    check_eq("gap_s2_ready_back", 32'(rdy2), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
